// File: rtl/fetch_if.sv
// Fetch-stage bundle: redirect input, instruction-memory handshake and the
// decode-facing instruction FIFO head.
interface fetch_if;
  logic        redirect;
  logic [31:0] npc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [31:0] inst_pc4;
  logic        inst_ready;
  logic        fetch_err;

  modport master (
    input  redirect, npc, imem_rvalid, imem_rdata, inst_ready,
    output imem_req, imem_addr, inst_valid, inst, inst_pc, inst_pc4, fetch_err
  );

  modport slave (
    output redirect, npc, imem_rvalid, imem_rdata, inst_ready,
    input  imem_req, imem_addr, inst_valid, inst, inst_pc, inst_pc4, fetch_err
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: owns fetch PC, issues sequential word fetches and queues
// {pc, inst} pairs toward decode; redirects flush, misaligned targets halt.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int          DEPTH    = 2
) (
  input  logic   clk,
  input  logic   reset,
  fetch_if.master bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  localparam logic [1:0] S_BOOT  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_FULL  = 2'd2;
  localparam logic [1:0] S_HALT  = 2'd3;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } entry_t;

  logic [1:0]    state, state_nxt;
  logic [31:0]   fetch_pc;
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   count, count_nxt;
  logic          fetch_err;
  entry_t        entry [DEPTH];
  entry_t        head;
  logic          halted, flush, push, pop, inst_valid;

  assign halted     = (state == S_HALT);
  assign flush      = bus.redirect && !halted;
  assign inst_valid = (count != '0) && !halted;
  // A redirect kills both the in-flight response and any pop that cycle.
  assign push       = (state == S_FETCH) && bus.imem_rvalid && !flush;
  assign pop        = inst_valid && bus.inst_ready && !flush;
  assign count_nxt  = count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = (bus.npc[1:0] == 2'b00) ? S_FETCH : S_HALT;
    end else begin
      case (state)
        S_BOOT:  state_nxt = S_FETCH;
        S_FETCH: if (push && count_nxt == FULL_CNT) state_nxt = S_FULL;
        S_FULL:  if (pop) state_nxt = S_FETCH;
        default: state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_BOOT;
      fetch_pc  <= RESET_PC;
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      fetch_err <= 1'b0;
    end else begin
      state <= state_nxt;
      if (flush) begin
        count <= '0;
        wptr  <= '0;
        rptr  <= '0;
        if (bus.npc[1:0] == 2'b00) fetch_pc  <= bus.npc;
        else                       fetch_err <= 1'b1;
      end else begin
        count <= count_nxt;
        if (push) begin
          wptr     <= wptr + AW'(1);
          fetch_pc <= fetch_pc + 32'd4;
        end
        if (pop) rptr <= rptr + AW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) entry[i] <= '0;
    end else if (push) begin
      entry[wptr] <= '{pc: fetch_pc, inst: bus.imem_rdata};
    end
  end

  assign head          = entry[rptr];
  assign bus.imem_req  = (state == S_FETCH);
  assign bus.imem_addr = fetch_pc;
  assign bus.inst_valid = inst_valid;
  assign bus.inst      = head.inst;
  assign bus.inst_pc   = head.pc;
  assign bus.inst_pc4  = head.pc + 32'd4;
  assign bus.fetch_err = fetch_err;
endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: queue-level reference model, randomized
// ready/latency/redirect stimulus plus directed stall, flush, halt, wrap, reset.
`timescale 1ns/1ps
module tb_fetch_unit;
  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam int          DEPTH    = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  fetch_if bus();

  fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0, failures = 0, delivered = 0;
  int          lat = 0, wait_cnt = 0;
  logic        m_boot = 1'b1, m_halt = 1'b0, m_err = 1'b0, m_req = 1'b0;
  logic [31:0] m_pc = RESET_PC;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_imem_req"},   32'(bus.imem_req),   32'd0);
    check({tag, "_imem_addr"},  bus.imem_addr,       RESET_PC);
    check({tag, "_inst_valid"}, 32'(bus.inst_valid), 32'd0);
    check({tag, "_fetch_err"},  32'(bus.fetch_err),  32'd0);
    check({tag, "_inst"},       bus.inst,            32'd0);
    check({tag, "_inst_pc"},    bus.inst_pc,         32'd0);
    check({tag, "_inst_pc4"},   bus.inst_pc4,        32'd4);
  endtask

  // Reference model: fetch stream as a queue of expected deliveries.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_boot = 1'b1; m_halt = 1'b0; m_err = 1'b0; m_pc = RESET_PC;
      exp_q.delete();
    end else if (!m_halt) begin
      if (bus.redirect) begin
        exp_q.delete();
        m_boot = 1'b0;
        if (bus.npc[1:0] != 2'b00) begin m_halt = 1'b1; m_err = 1'b1; end
        else m_pc = bus.npc;
      end else begin
        if (m_req && bus.imem_rvalid) begin
          exp_q.push_back('{pc: m_pc, inst: mem_word(m_pc)});
          m_pc = m_pc + 32'd4;
        end
        m_boot = 1'b0;
      end
    end
    m_req = !m_boot && !m_halt && (exp_q.size() < DEPTH);
  end

  // Monitor: compares what the DUT presents and retires consumed entries.
  always @(negedge clk) begin
    if (rst_n) begin
      check("imem_req",   32'(bus.imem_req),   32'(m_req));
      check("imem_addr",  bus.imem_addr,       m_pc);
      check("inst_valid", 32'(bus.inst_valid), 32'(exp_q.size() != 0 && !m_halt));
      check("fetch_err",  32'(bus.fetch_err),  32'(m_err));
      if (exp_q.size() != 0 && !m_halt) begin
        check("inst_pc",  bus.inst_pc,  exp_q[0].pc);
        check("inst",     bus.inst,     exp_q[0].inst);
        check("inst_pc4", bus.inst_pc4, exp_q[0].pc + 32'd4);
        if (bus.inst_ready && !bus.redirect) begin
          void'(exp_q.pop_front());
          delivered++;
        end
      end
    end
  end

  // Drive one cycle of inputs (called just after a rising edge).
  task automatic step(input bit rdy, input bit rd, input logic [31:0] tgt);
    bit waiting;
    bus.inst_ready  = rdy;
    bus.redirect    = rd;
    bus.npc         = tgt;
    bus.imem_rvalid = m_req && rst_n && (wait_cnt >= lat);
    bus.imem_rdata  = bus.imem_rvalid ? mem_word(bus.imem_addr) : 32'h0;
    waiting = m_req && !bus.imem_rvalid && !rd;
    @(posedge clk); #1;
    if (waiting) wait_cnt++;
    else wait_cnt = 0;
  endtask

  task automatic idle_inputs();
    bus.redirect = 1'b0; bus.npc = 32'h0; bus.imem_rvalid = 1'b0;
    bus.imem_rdata = 32'h0; bus.inst_ready = 1'b0; wait_cnt = 0;
  endtask

  initial begin
    idle_inputs();
    #1 rst_n = 1'b0;
    #2 check_reset("por");
    @(posedge clk); #1; rst_n = 1'b1;

    // Stall from boot: two pushes fill the FIFO, fetch stops at 0x3008.
    repeat (5) step(1'b0, 1'b0, 32'h0);
    check("stall_head_pc", bus.inst_pc, 32'h3000);
    check("stall_req",     32'(bus.imem_req), 32'd0);
    check("stall_addr",    bus.imem_addr, 32'h3008);

    repeat (12) step(1'b1, 1'b0, 32'h0);

    // Redirect colliding with a response and a pop on a non-empty FIFO.
    step(1'b1, 1'b1, 32'h3040);
    check("redir_valid", 32'(bus.inst_valid), 32'd0);
    check("redir_addr",  bus.imem_addr, 32'h3040);
    step(1'b1, 1'b0, 32'h0);
    check("redir_first_pc", bus.inst_pc, 32'h3040);
    repeat (6) step(1'b1, 1'b0, 32'h0);

    // Slow memory.
    lat = 3;
    repeat (20) step(1'b1, 1'b0, 32'h0);

    // Randomized mix of ready, latency and aligned redirects.
    repeat (400) begin
      lat = $urandom_range(0, 2);
      step($urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0,
           ($urandom_range(0, 1) == 0) ? 32'hFFFF_FFF0 : ($urandom() & 32'h0000_FFFC));
    end

    // Wrap across the top of the address space.
    lat = 0;
    step(1'b1, 1'b1, 32'hFFFF_FFF8);
    repeat (2) step(1'b1, 1'b0, 32'h0);
    check("wrap_addr", bus.imem_addr, 32'h0000_0000);
    repeat (3) step(1'b1, 1'b0, 32'h0);

    // Asynchronous reset mid-cycle with the FIFO full.
    repeat (4) step(1'b0, 1'b0, 32'h0);
    check("full_before_reset", 32'(bus.imem_req), 32'd0);
    #2 rst_n = 1'b0;
    #1 check_reset("mid");
    idle_inputs();
    @(posedge clk); #1; rst_n = 1'b1;
    repeat (6) step(1'b1, 1'b0, 32'h0);

    // Misaligned redirect halts permanently until reset.
    step(1'b1, 1'b1, 32'h3042);
    check("halt_err",   32'(bus.fetch_err),  32'd1);
    check("halt_valid", 32'(bus.inst_valid), 32'd0);
    repeat (6) step($urandom_range(0, 1) != 0, 1'b1, 32'h3100);
    check("halt_ignores_redirect", bus.imem_addr, m_pc);
    rst_n = 1'b0;
    #1 check_reset("post_halt");
    idle_inputs();
    @(posedge clk); #1; rst_n = 1'b1;
    repeat (8) step(1'b1, 1'b0, 32'h0);

    check("delivered_min", 32'(delivered >= 50), 32'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage that owns the architectural fetch PC register and sits directly downstream of the next-PC logic. It issues sequential fetches to instruction memory over a valid/response handshake and buffers fetched {PC, instruction} pairs in a small FIFO toward decode. It also accepts redirects: the next-PC value on a taken branch, jump or jr flushes the buffer and restarts fetch. Misaligned redirect targets halt fetch with a sticky error.

## Interface
- RESET_PC, 32'h0000_3000, fetch PC loaded at reset
- DEPTH, 2, instruction FIFO entries (power of two, ≥2)

- clk  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-low reset
- redirect  in  1  one-cycle pulse: load npc as fetch PC, flush FIFO
- npc  in  32  redirect target from next-PC logic
- imem_req  out  1  fetch request valid
- imem_addr  out  32  word address of request; equals fetch_pc
- imem_rvalid  in  1  response for the current request; legal only while imem_req=1, may be in the same cycle (zero-wait)
- imem_rdata  in  32  instruction, valid with imem_rvalid
- inst_valid  out  1  FIFO head valid
- inst  out  32  FIFO head instruction
- inst_pc  out  32  PC of FIFO head
- inst_pc4  out  32  inst_pc+4, for link/branch base
- inst_ready  in  1  decode consumes head when inst_valid&inst_ready
- fetch_err  out  1  sticky misaligned-redirect flag

## Operation
- State machine:
  - BOOT: entered on reset; imem_req=0; always goes to FETCH next cycle.
  - FETCH: imem_req=1, imem_addr=fetch_pc.
  - FULL: count==DEPTH; imem_req=0.
  - HALT: imem_req=0; inst_valid=0.
- FETCH, rvalid=1 with no redirect: push {fetch_pc, imem_rdata}; fetch_pc <= fetch_pc+4 (mod 2^32, wraps silently).
  - Next state is FULL if post-update count==DEPTH, otherwise FETCH.
- FULL: go to FETCH on the cycle a pop occurs.
- Count update:
  - push and pop in the same cycle: count unchanged.
  - A pop frees space usable by a push in the same cycle, so FETCH with count==DEPTH-1, rvalid and pop stays in FETCH.
- Redirect handling (priority over push, pop, state), in any state except HALT:
  - Any response in that cycle is discarded.
  - FIFO count <= 0; any pop that cycle is ignored.
  - If npc[1:0]==0: fetch_pc <= npc and next state FETCH.
  - If npc[1:0]!=0: fetch_err <= 1 and next state HALT.
  - redirect during BOOT is applied as above.
- HALT: ignores redirect, rvalid and inst_ready; left only via reset.
- inst_valid = (count!=0) and state!=HALT. inst, inst_pc and inst_pc4 come from the head entry and hold while inst_valid & !inst_ready.
- FIFO: circular read/write pointers of log2(DEPTH) bits, wrapping modulo DEPTH; count of log2(DEPTH)+1 bits.

## Timing
- Reset (asynchronous assert, any time including mid-request):
  - state=BOOT, fetch_pc=RESET_PC, count=0, pointers=0, fetch_err=0.
  - imem_req=0, imem_addr=RESET_PC, inst_valid=0.
  - inst and inst_pc read the (don't-care) head entry; entries are cleared to 0 at reset so they read 0.
- First imem_req=1 at RESET_PC: the first rising edge after deassertion moves BOOT→FETCH, so imem_req is high in the cycle after that edge.
- Latency: a response sampled at edge N gives inst_valid=1 after edge N; a zero-wait response is presented to decode one cycle after its request.
- Throughput: one instruction per cycle with zero-wait memory and inst_ready held high.
- Redirect sampled at edge N: imem_addr=npc after edge N; inst_valid=0 after edge N.
- All outputs are registered or decoded from state/FIFO registers; none depends combinationally on imem_rvalid, redirect or inst_ready.

## Test plan
- Reset then zero-wait memory, inst_ready=1: imem_addr runs 0x3000, 0x3004, 0x3008…; inst_pc tracks one cycle behind; inst_pc4=inst_pc+4.
- inst_ready=0 for 5 cycles: after 2 pushes, state FULL and imem_req=0; entries at 0x3000/0x3004 held unchanged. Raising inst_ready resumes fetch at 0x3008 with no duplicate or lost instruction.
- Redirect npc=0x3040 in the same cycle as rvalid and pop with FIFO non-empty: response dropped, inst_valid=0 next cycle, then the first delivered inst_pc=0x3040.
- Redirect npc=0x3042: fetch_err=1, imem_req=0 and inst_valid=0 permanently; a later redirect to 0x3100 is ignored; reset clears fetch_err to 0.
- Memory with 3-cycle response latency: imem_addr stable while waiting; exactly one push per rvalid.
- Reset asserted mid-request with FIFO full: outputs return immediately to their reset values; fetch restarts at 0x3000.
- Fetch across 0xFFFF_FFFC: next imem_addr is 0x0000_0000.
